// File: rtl/line_follow_ctrl_if.sv
// ---------------------------------------------------------------------------
// line_follow_ctrl_if
// Bundles the run request, track sensor, ultrasonic distance and the motor
// decision outputs of line_follow_ctrl into one interface.
//   master : drives enable, track, distance, dist_valid; observes outputs
//   slave  : the controller; receives inputs, drives mode/state/obstacle/lost
// Signals:
//   enable     run request, level-sensitive
//   track      raw sensor bits, 1 = line seen (asynchronous to clk)
//   distance   ultrasonic distance in cm, valid with dist_valid
//   dist_valid one-cycle strobe marking a new distance
//   mode       motor mode (0 STOP .. 5 SHARP_RIGHT)
//   state      controller state (0 IDLE .. 5 HALT)
//   obstacle   filtered obstacle flag
//   lost       high while holding or searching for a lost line
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface line_follow_ctrl_if #(
   parameter int N_TRACK = 3,
   parameter int DIST_W  = 20
);
   logic               enable;
   logic [N_TRACK-1:0] track;
   logic [DIST_W-1:0]  distance;
   logic               dist_valid;
   logic [2:0]         mode;
   logic [2:0]         state;
   logic               obstacle;
   logic               lost;

   modport master (
      output enable, track, distance, dist_valid,
      input  mode, state, obstacle, lost
   );

   modport slave (
      input  enable, track, distance, dist_valid,
      output mode, state, obstacle, lost
   );
endinterface

// File: rtl/line_follow_ctrl.sv
// ---------------------------------------------------------------------------
// line_follow_ctrl
// Top-level motor decision logic for the line-following car. Fuses an
// N_TRACK-channel track sensor (synchronised and debounced) with ultrasonic
// distance readings (hysteresis plus a no-echo watchdog) and drives a
// registered 3-bit motor mode through a follow / blocked / lost-line
// recovery state machine.
// Ports:
//   clk  system clock
//   rst  asynchronous, active-low reset
//   bus  line_follow_ctrl_if.slave (enable, track, distance, dist_valid in;
//        mode, state, obstacle, lost out -- all outputs registered)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module line_follow_ctrl #(
   parameter int N_TRACK        = 3,
   parameter int DIST_W         = 20,
   parameter int STOP_DIST      = 15,
   parameter int GO_DIST        = 20,
   parameter int FILT_LEN       = 16,
   parameter int LOST_TIMEOUT   = 5000000,
   parameter int SEARCH_TIMEOUT = 200000000,
   parameter int SONIC_TIMEOUT  = 20000000
) (
   input  logic               clk,
   input  logic               rst,
   line_follow_ctrl_if.slave  bus
);

   localparam int C       = N_TRACK / 2;
   localparam int FCNT_W  = $clog2(FILT_LEN + 1);
   localparam int WD_W    = $clog2(SONIC_TIMEOUT + 1);
   localparam int TMR_MAX = (SEARCH_TIMEOUT > LOST_TIMEOUT) ? SEARCH_TIMEOUT : LOST_TIMEOUT;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [FCNT_W-1:0] FILT_MAX   = FCNT_W'(FILT_LEN);
   localparam logic [WD_W-1:0]   WD_MAX     = WD_W'(SONIC_TIMEOUT);
   localparam logic [WD_W-1:0]   WD_TRIP    = WD_W'(SONIC_TIMEOUT - 1);
   localparam logic [TMR_W-1:0]  LOST_END   = TMR_W'(LOST_TIMEOUT - 1);
   localparam logic [TMR_W-1:0]  SEARCH_END = TMR_W'(SEARCH_TIMEOUT - 1);
   localparam logic [DIST_W-1:0] STOP_LIM   = DIST_W'(STOP_DIST);
   localparam logic [DIST_W-1:0] GO_LIM     = DIST_W'(GO_DIST);

   // Motor modes; M_NONE is only a classification result, never driven out.
   localparam logic [2:0] M_STOP        = 3'd0;
   localparam logic [2:0] M_FWD         = 3'd1;
   localparam logic [2:0] M_LEFT        = 3'd2;
   localparam logic [2:0] M_RIGHT       = 3'd3;
   localparam logic [2:0] M_SHARP_LEFT  = 3'd4;
   localparam logic [2:0] M_SHARP_RIGHT = 3'd5;
   localparam logic [2:0] M_NONE        = 3'd7;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FOLLOW    = 3'd1,
      S_BLOCKED   = 3'd2,
      S_LOST_HOLD = 3'd3,
      S_SEARCH    = 3'd4,
      S_HALT      = 3'd5
   } state_t;

   // Spin toward the side the line was last seen on.
   function automatic logic [2:0] search_mode(input logic dir);
      if (dir == DIR_LEFT) begin
         search_mode = M_SHARP_LEFT;
      end else begin
         search_mode = M_SHARP_RIGHT;
      end
   endfunction

   logic [N_TRACK-1:0] s1_q, s1_d, s2_q, s2_d;
   logic [N_TRACK-1:0] cand_q, cand_d, track_f_q, track_f_d;
   logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
   logic [WD_W-1:0]    wd_q, wd_d;
   logic               obst_q, obst_d;
   state_t             state_q, state_d;
   logic [2:0]         mode_q, mode_d;
   logic               lost_q, lost_d;
   logic               last_dir_q, last_dir_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [2:0]         cls;
   logic               side_l, side_r;

   // Synchroniser and debounce: track_f only takes s2 after FILT_LEN equal samples.
   always_comb begin
      s1_d      = bus.track;
      s2_d      = s1_q;
      cand_d    = cand_q;
      fcnt_d    = fcnt_q;
      track_f_d = track_f_q;
      if (s2_q != cand_q) begin
         cand_d = s2_q;
         fcnt_d = FCNT_W'(1);
      end else if (fcnt_q != FILT_MAX) begin
         fcnt_d = fcnt_q + FCNT_W'(1);
      end else begin
         fcnt_d = fcnt_q;
      end
      // The count includes the current cycle, so FILT_LEN=1 is a plain register.
      if (fcnt_d == FILT_MAX) begin
         track_f_d = s2_q;
      end else begin
         track_f_d = track_f_q;
      end
   end

   // Classify the debounced track pattern into a steering request.
   always_comb begin
      side_l = |track_f_q[N_TRACK-1:C+1];
      side_r = |track_f_q[C-1:0];
      cls    = M_NONE;
      if (side_l && !side_r) begin
         cls = (track_f_q[N_TRACK-1] && !track_f_q[C]) ? M_SHARP_LEFT : M_LEFT;
      end else if (side_r && !side_l) begin
         cls = (track_f_q[0] && !track_f_q[C]) ? M_SHARP_RIGHT : M_RIGHT;
      end else if (track_f_q != '0) begin
         cls = M_FWD;
      end else begin
         cls = M_NONE;
      end
   end

   // Obstacle hysteresis and watchdog; distance 0 means no echo and never changes the flag.
   always_comb begin
      obst_d = obst_q;
      wd_d   = wd_q;
      if (bus.dist_valid) begin
         wd_d = '0;
         if (bus.distance == '0) begin
            obst_d = obst_q;
         end else if (bus.distance < STOP_LIM) begin
            obst_d = 1'b1;
         end else if (bus.distance >= GO_LIM) begin
            obst_d = 1'b0;
         end else begin
            obst_d = obst_q;
         end
      end else if (wd_q != WD_MAX) begin
         wd_d = wd_q + WD_W'(1);
         // Trip on the edge where the counter reaches SONIC_TIMEOUT.
         if (wd_q == WD_TRIP) begin
            obst_d = 1'b1;
         end else begin
            obst_d = obst_q;
         end
      end else begin
         wd_d   = wd_q;
         obst_d = obst_q;
      end
   end

   // Controller next state; mode/state/lost are computed together so they change on one edge.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      timer_d    = timer_q;
      last_dir_d = last_dir_q;
      if (!bus.enable) begin
         state_d = S_IDLE;
         mode_d  = M_STOP;
         timer_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_FOLLOW;
               mode_d  = M_STOP;
            end
            S_FOLLOW: begin
               if (cls == M_LEFT || cls == M_SHARP_LEFT) begin
                  last_dir_d = DIR_LEFT;
               end else if (cls == M_RIGHT || cls == M_SHARP_RIGHT) begin
                  last_dir_d = DIR_RIGHT;
               end else begin
                  last_dir_d = last_dir_q;
               end
               if (obst_q) begin
                  state_d = S_BLOCKED;
                  mode_d  = M_STOP;
               end else if (cls == M_NONE) begin
                  state_d = S_LOST_HOLD;
                  timer_d = '0;
               end else begin
                  mode_d = cls;
               end
            end
            S_LOST_HOLD: begin
               if (obst_q) begin
                  state_d = S_BLOCKED;
                  mode_d  = M_STOP;
               end else if (cls != M_NONE) begin
                  state_d = S_FOLLOW;
                  mode_d  = cls;
               end else if (timer_q == LOST_END) begin
                  state_d = S_SEARCH;
                  mode_d  = search_mode(last_dir_q);
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
            S_SEARCH: begin
               if (obst_q) begin
                  state_d = S_BLOCKED;
                  mode_d  = M_STOP;
               end else if (cls != M_NONE) begin
                  state_d = S_FOLLOW;
                  mode_d  = cls;
               end else if (timer_q == SEARCH_END) begin
                  state_d = S_HALT;
                  mode_d  = M_STOP;
               end else begin
                  mode_d  = search_mode(last_dir_q);
                  timer_d = timer_q + TMR_W'(1);
               end
            end
            S_BLOCKED: begin
               // Leave with STOP; FOLLOW picks up the track on the next cycle.
               mode_d = M_STOP;
               if (!obst_q) begin
                  state_d = S_FOLLOW;
               end else begin
                  state_d = S_BLOCKED;
               end
            end
            S_HALT: begin
               state_d = S_HALT;
               mode_d  = M_STOP;
            end
            default: begin
               state_d = S_IDLE;
               mode_d  = M_STOP;
               timer_d = '0;
            end
         endcase
      end
      lost_d = (state_d == S_LOST_HOLD) || (state_d == S_SEARCH);
   end

   // All state registers; reset leaves the car stopped with the obstacle flag fail-safe high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q       <= '0;
         s2_q       <= '0;
         cand_q     <= '0;
         fcnt_q     <= '0;
         track_f_q  <= '0;
         wd_q       <= '0;
         obst_q     <= 1'b1;
         state_q    <= S_IDLE;
         mode_q     <= M_STOP;
         lost_q     <= 1'b0;
         last_dir_q <= DIR_LEFT;
         timer_q    <= '0;
      end else begin
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         cand_q     <= cand_d;
         fcnt_q     <= fcnt_d;
         track_f_q  <= track_f_d;
         wd_q       <= wd_d;
         obst_q     <= obst_d;
         state_q    <= state_d;
         mode_q     <= mode_d;
         lost_q     <= lost_d;
         last_dir_q <= last_dir_d;
         timer_q    <= timer_d;
      end
   end

   assign bus.mode     = mode_q;
   assign bus.state    = state_q;
   assign bus.obstacle = obst_q;
   assign bus.lost     = lost_q;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// ---------------------------------------------------------------------------
// tb_line_follow_ctrl
// Directed testbench for line_follow_ctrl with N_TRACK=3, FILT_LEN=4,
// LOST_TIMEOUT=10, SEARCH_TIMEOUT=20, SONIC_TIMEOUT=1000. Each task drives
// one scenario and compares outputs against hand-computed values.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_line_follow_ctrl;
   localparam int DIST_W = 20;

   logic clk = 1'b0;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   line_follow_ctrl_if #(.N_TRACK(3), .DIST_W(DIST_W)) bus ();

   line_follow_ctrl #(
      .N_TRACK(3), .DIST_W(DIST_W), .STOP_DIST(15), .GO_DIST(20), .FILT_LEN(4),
      .LOST_TIMEOUT(10), .SEARCH_TIMEOUT(20), .SONIC_TIMEOUT(1000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_dist(input int d);
      bus.distance   = DIST_W'(d);
      bus.dist_valid = 1'b1;
      tick(1);
      bus.dist_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0; bus.enable = 1'b0; bus.track = 3'b010;
      bus.distance = '0; bus.dist_valid = 1'b0;
      #12;
      vectors++; if (bus.mode !== 3'd0) begin miscompares++; $display("FAIL reset_mode got %0d want 0", bus.mode); end
      vectors++; if (bus.state !== 3'd0) begin miscompares++; $display("FAIL reset_state got %0d want 0", bus.state); end
      vectors++; if (bus.obstacle !== 1'b1) begin miscompares++; $display("FAIL reset_obstacle got %0b want 1", bus.obstacle); end
      vectors++; if (bus.lost !== 1'b0) begin miscompares++; $display("FAIL reset_lost got %0b want 0", bus.lost); end
      rst = 1'b1;
      pulse_dist(30);
      vectors++; if (bus.obstacle !== 1'b0) begin miscompares++; $display("FAIL start_obstacle got %0b want 0", bus.obstacle); end
      tick(6);
      bus.enable = 1'b1;
      tick(1);
      vectors++; if (bus.state !== 3'd1 || bus.mode !== 3'd0) begin miscompares++; $display("FAIL start_follow state=%0d mode=%0d want 1/0", bus.state, bus.mode); end
      tick(1);
      vectors++; if (bus.mode !== 3'd1 || bus.state !== 3'd1) begin miscompares++; $display("FAIL start_fwd mode=%0d state=%0d want 1/1", bus.mode, bus.state); end
   endtask

   task automatic test_track;
      bus.track = 3'b110;
      tick(6);
      vectors++; if (bus.mode !== 3'd1) begin miscompares++; $display("FAIL trk_110_early got %0d want 1", bus.mode); end
      tick(1);
      vectors++; if (bus.mode !== 3'd2) begin miscompares++; $display("FAIL trk_110 got %0d want 2", bus.mode); end
      bus.track = 3'b100;
      tick(6);
      vectors++; if (bus.mode !== 3'd2) begin miscompares++; $display("FAIL trk_100_early got %0d want 2", bus.mode); end
      tick(1);
      vectors++; if (bus.mode !== 3'd4) begin miscompares++; $display("FAIL trk_100 got %0d want 4", bus.mode); end
      bus.track = 3'b001;
      tick(3);
      bus.track = 3'b100;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         vectors++; if (bus.mode !== 3'd4 || bus.state !== 3'd1) begin miscompares++; $display("FAIL glitch[%0d] mode=%0d state=%0d want 4/1", i, bus.mode, bus.state); end
      end
   endtask

   task automatic test_obstacle;
      pulse_dist(30);
      vectors++; if (bus.obstacle !== 1'b0) begin miscompares++; $display("FAIL obs_30 got %0b want 0", bus.obstacle); end
      pulse_dist(14);
      vectors++; if (bus.obstacle !== 1'b1 || bus.state !== 3'd1) begin miscompares++; $display("FAIL obs_14 obs=%0b state=%0d want 1/1", bus.obstacle, bus.state); end
      tick(1);
      vectors++; if (bus.state !== 3'd2 || bus.mode !== 3'd0) begin miscompares++; $display("FAIL obs_blocked state=%0d mode=%0d want 2/0", bus.state, bus.mode); end
      pulse_dist(17);
      vectors++; if (bus.obstacle !== 1'b1) begin miscompares++; $display("FAIL obs_17 got %0b want 1", bus.obstacle); end
      pulse_dist(0);
      vectors++; if (bus.obstacle !== 1'b1) begin miscompares++; $display("FAIL obs_0_set got %0b want 1", bus.obstacle); end
      pulse_dist(19);
      vectors++; if (bus.obstacle !== 1'b1 || bus.state !== 3'd2) begin miscompares++; $display("FAIL obs_19 obs=%0b state=%0d want 1/2", bus.obstacle, bus.state); end
      pulse_dist(20);
      vectors++; if (bus.obstacle !== 1'b0 || bus.state !== 3'd2) begin miscompares++; $display("FAIL obs_20 obs=%0b state=%0d want 0/2", bus.obstacle, bus.state); end
      tick(1);
      vectors++; if (bus.state !== 3'd1 || bus.mode !== 3'd0) begin miscompares++; $display("FAIL obs_release state=%0d mode=%0d want 1/0", bus.state, bus.mode); end
      tick(1);
      vectors++; if (bus.mode !== 3'd4) begin miscompares++; $display("FAIL obs_reeval got %0d want 4", bus.mode); end
      pulse_dist(0);
      vectors++; if (bus.obstacle !== 1'b0 || bus.state !== 3'd1) begin miscompares++; $display("FAIL obs_0_clr obs=%0b state=%0d want 0/1", bus.obstacle, bus.state); end
   endtask

   task automatic test_lost;
      pulse_dist(30);
      bus.track = 3'b011;
      tick(7);
      vectors++; if (bus.mode !== 3'd3 || bus.state !== 3'd1) begin miscompares++; $display("FAIL lost_right mode=%0d state=%0d want 3/1", bus.mode, bus.state); end
      bus.track = 3'b000;
      tick(7);
      vectors++; if (bus.state !== 3'd3 || bus.mode !== 3'd3 || bus.lost !== 1'b1) begin miscompares++; $display("FAIL lost_hold state=%0d mode=%0d lost=%0b want 3/3/1", bus.state, bus.mode, bus.lost); end
      tick(9);
      vectors++; if (bus.state !== 3'd3 || bus.mode !== 3'd3) begin miscompares++; $display("FAIL lost_hold_end state=%0d mode=%0d want 3/3", bus.state, bus.mode); end
      tick(1);
      vectors++; if (bus.state !== 3'd4 || bus.mode !== 3'd5 || bus.lost !== 1'b1) begin miscompares++; $display("FAIL lost_search state=%0d mode=%0d lost=%0b want 4/5/1", bus.state, bus.mode, bus.lost); end
      tick(19);
      vectors++; if (bus.state !== 3'd4 || bus.mode !== 3'd5) begin miscompares++; $display("FAIL lost_search_end state=%0d mode=%0d want 4/5", bus.state, bus.mode); end
      tick(1);
      vectors++; if (bus.state !== 3'd5 || bus.mode !== 3'd0 || bus.lost !== 1'b0) begin miscompares++; $display("FAIL lost_halt state=%0d mode=%0d lost=%0b want 5/0/0", bus.state, bus.mode, bus.lost); end
      bus.enable = 1'b0;
      tick(1);
      vectors++; if (bus.state !== 3'd0) begin miscompares++; $display("FAIL lost_idle got %0d want 0", bus.state); end
      bus.enable = 1'b1;
      tick(1);
      vectors++; if (bus.state !== 3'd1) begin miscompares++; $display("FAIL lost_refollow got %0d want 1", bus.state); end
   endtask

   task automatic test_search_recover;
      pulse_dist(30);
      vectors++; if (bus.state !== 3'd3) begin miscompares++; $display("FAIL rec_hold got %0d want 3", bus.state); end
      tick(10);
      vectors++; if (bus.state !== 3'd4 || bus.mode !== 3'd5) begin miscompares++; $display("FAIL rec_search state=%0d mode=%0d want 4/5", bus.state, bus.mode); end
      bus.track = 3'b010;
      tick(6);
      vectors++; if (bus.state !== 3'd4) begin miscompares++; $display("FAIL rec_early got %0d want 4", bus.state); end
      tick(1);
      vectors++; if (bus.state !== 3'd1 || bus.mode !== 3'd1 || bus.lost !== 1'b0) begin miscompares++; $display("FAIL rec_follow state=%0d mode=%0d lost=%0b want 1/1/0", bus.state, bus.mode, bus.lost); end
      bus.track = 3'b000;
      tick(7);
      vectors++; if (bus.state !== 3'd3 || bus.mode !== 3'd1) begin miscompares++; $display("FAIL rec_hold2 state=%0d mode=%0d want 3/1", bus.state, bus.mode); end
      tick(10);
      vectors++; if (bus.state !== 3'd4 || bus.mode !== 3'd5) begin miscompares++; $display("FAIL rec_search2 state=%0d mode=%0d want 4/5", bus.state, bus.mode); end
      pulse_dist(5);
      vectors++; if (bus.obstacle !== 1'b1 || bus.state !== 3'd4) begin miscompares++; $display("FAIL rec_obs obs=%0b state=%0d want 1/4", bus.obstacle, bus.state); end
      tick(1);
      vectors++; if (bus.state !== 3'd2 || bus.mode !== 3'd0 || bus.lost !== 1'b0) begin miscompares++; $display("FAIL rec_blocked state=%0d mode=%0d lost=%0b want 2/0/0", bus.state, bus.mode, bus.lost); end
   endtask

   task automatic test_watchdog_and_async_reset;
      bus.track = 3'b010;
      pulse_dist(30);
      tick(999);
      vectors++; if (bus.obstacle !== 1'b0 || bus.state !== 3'd1 || bus.mode !== 3'd1) begin miscompares++; $display("FAIL wd_early obs=%0b state=%0d mode=%0d want 0/1/1", bus.obstacle, bus.state, bus.mode); end
      tick(1);
      vectors++; if (bus.obstacle !== 1'b1) begin miscompares++; $display("FAIL wd_trip got %0b want 1", bus.obstacle); end
      tick(1);
      vectors++; if (bus.state !== 3'd2 || bus.mode !== 3'd0) begin miscompares++; $display("FAIL wd_blocked state=%0d mode=%0d want 2/0", bus.state, bus.mode); end
      pulse_dist(30);
      tick(1);
      bus.track = 3'b000;
      tick(7);
      vectors++; if (bus.state !== 3'd3) begin miscompares++; $display("FAIL ar_hold got %0d want 3", bus.state); end
      tick(10);
      vectors++; if (bus.state !== 3'd4 || bus.mode !== 3'd5) begin miscompares++; $display("FAIL ar_search state=%0d mode=%0d want 4/5", bus.state, bus.mode); end
      #2;
      rst = 1'b0;
      #1;
      vectors++; if (bus.mode !== 3'd0 || bus.state !== 3'd0 || bus.obstacle !== 1'b1 || bus.lost !== 1'b0) begin miscompares++; $display("FAIL ar_async mode=%0d state=%0d obs=%0b lost=%0b want 0/0/1/0", bus.mode, bus.state, bus.obstacle, bus.lost); end
      rst = 1'b1;
      tick(1);
   endtask

   initial begin
      test_reset();
      test_track();
      test_obstacle();
      test_lost();
      test_search_recover();
      test_watchdog_and_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
